// File: rtl/pmem_arbiter.sv
// Two-port line arbiter and burst sequencer between the I-cache, the D-cache and
// a single burst-mode memory port; lines move as BURST_LEN beats of BURST_WIDTH bits.
module pmem_arbiter #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BURST_LEN        = 4,
    parameter int BURST_WIDTH      = CACHE_LINE_WIDTH / BURST_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_read,
    input  logic [31:0]                 i_addr,
    output logic [CACHE_LINE_WIDTH-1:0] i_rdata,
    output logic                        i_resp,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [31:0]                 d_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] d_wdata,
    output logic [CACHE_LINE_WIDTH-1:0] d_rdata,
    output logic                        d_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [31:0]                 pmem_addr,
    output logic [BURST_WIDTH-1:0]      pmem_wdata,
    input  logic [BURST_WIDTH-1:0]      pmem_rdata,
    input  logic                        pmem_resp,
    input  logic                        pmem_error,
    output logic                        err
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFF_W  = $clog2(CACHE_LINE_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                                 state_r;
    state_t                                 state_s;
    logic                                   owner_r;       // 1'b1 = D-cache
    logic                                   op_r;          // 1'b1 = write
    logic                                   last_owner_r;
    logic [BEAT_W-1:0]                      beat_r;
    logic [31:0]                            addr_r;
    logic [BURST_LEN-1:0][BURST_WIDTH-1:0]  line_r;
    logic                                   err_r;
    logic                                   pmem_read_r;
    logic                                   pmem_write_r;
    logic                                   i_resp_r;
    logic                                   d_resp_r;
    logic                                   d_req_s;
    logic                                   grant_s;
    logic                                   grant_d_s;
    logic                                   grant_wr_s;
    logic                                   last_beat_s;

    // Next-state decode and round-robin arbitration.
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_d_s   = 1'b0;
        grant_wr_s  = 1'b0;
        d_req_s     = d_read | d_write;
        last_beat_s = pmem_resp && (beat_r == LAST_BEAT);
        case (state_r)
            IDLE: begin
                if (i_read || d_req_s) begin
                    grant_s    = 1'b1;
                    // On contention the port that did not finish last wins.
                    grant_d_s  = d_req_s && (!i_read || (last_owner_r == 1'b0));
                    grant_wr_s = grant_d_s && d_write;
                    state_s    = BUSY;
                end else begin
                    state_s    = IDLE;
                end
            end
            BUSY: begin
                if (last_beat_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Transaction registers, beat sequencing and registered command/response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            op_r         <= 1'b0;
            last_owner_r <= 1'b1;
            beat_r       <= {BEAT_W{1'b0}};
            addr_r       <= 32'h0000_0000;
            line_r       <= {CACHE_LINE_WIDTH{1'b0}};
            err_r        <= 1'b0;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            err_r   <= err_r | pmem_error;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_r      <= grant_d_s;
                        op_r         <= grant_wr_s;
                        addr_r       <= (grant_d_s ? d_addr : i_addr) & ADDR_MASK;
                        beat_r       <= {BEAT_W{1'b0}};
                        pmem_read_r  <= ~grant_wr_s;
                        pmem_write_r <= grant_wr_s;
                        if (grant_wr_s) begin
                            line_r <= d_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        if (!op_r) begin
                            line_r[beat_r] <= pmem_rdata;
                        end
                        beat_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_r + 1'b1;
                        // Drop the command together with the final beat so it is low in DONE.
                        if (last_beat_s) begin
                            last_owner_r <= owner_r;
                            pmem_read_r  <= 1'b0;
                            pmem_write_r <= 1'b0;
                            i_resp_r     <= ~owner_r;
                            d_resp_r     <= owner_r;
                        end
                    end
                end
                DONE: begin
                    i_resp_r <= 1'b0;
                    d_resp_r <= 1'b0;
                end
                default: begin
                    i_resp_r <= 1'b0;
                    d_resp_r <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read  = pmem_read_r;
    assign pmem_write = pmem_write_r;
    assign pmem_addr  = addr_r;
    assign pmem_wdata = line_r[beat_r];
    assign i_rdata    = line_r;
    assign d_rdata    = line_r;
    assign i_resp     = i_resp_r;
    assign d_resp     = d_resp_r;
    assign err        = err_r;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: a behavioural burst memory with a sparse
// line store, a round-robin grant model and directed plus randomized requests.
module tb_pmem_arbiter;
    localparam int LW = 256;
    localparam int BL = 4;
    localparam int BW = LW / BL;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write;
    logic [31:0]   i_addr, d_addr;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata;
    logic          i_resp, d_resp;
    logic          pmem_read, pmem_write, pmem_resp, pmem_error, err;
    logic [31:0]   pmem_addr;
    logic [BW-1:0] pmem_wdata, pmem_rdata;

    pmem_arbiter #(.CACHE_LINE_WIDTH(LW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pmem_error(pmem_error), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mem [logic [31:0]];
    logic [31:0] cmd_addr_q [$];
    logic        cmd_wr_q [$];
    logic        lo_m;           // model of last finished owner, 1 = D
    int          fix_delay = 0;  // < 0 selects a random delay
    logic        gap_en = 1'b0, stray_en = 1'b0, err_req = 1'b0;
    logic        active = 1'b0, cur_wr = 1'b0, rel_chk = 1'b0;
    logic [31:0] cur_addr = 32'h0;
    int          bi = 0, dly = 0, cmd_cycles = 0, last_cmd_cycles = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 32'hC3C3_0000, ~a};
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int b = 0; b < BL; b++) l[64*b +: 64] = rd(a + 32'(8 * b));
        return l;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    // Burst memory: optional initial delay, optional gaps between beats, stray strobes.
    initial begin
        pmem_resp = 1'b0; pmem_error = 1'b0; pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_error = 1'b0;
            if (rst) begin
                active = 1'b0; rel_chk = 1'b0; bi = 0;
            end else begin
                if (rel_chk) begin
                    chk("cmd_release", {pmem_read, pmem_write}, 2'b00);
                    rel_chk = 1'b0;
                end
                if (!active && (pmem_read || pmem_write)) begin
                    active = 1'b1; cur_addr = pmem_addr; cur_wr = pmem_write;
                    bi = 0; cmd_cycles = 0;
                    dly = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 3);
                    cmd_addr_q.push_back(pmem_addr);
                    cmd_wr_q.push_back(pmem_write);
                end
                if (active) begin
                    chk("cmd_hold", {pmem_read, pmem_write, pmem_addr}, {~cur_wr, cur_wr, cur_addr});
                    cmd_cycles++;
                    if (err_req) begin
                        pmem_error = 1'b1; err_req = 1'b0;
                    end
                    if (dly > 0) begin
                        dly--;
                    end else if (!(gap_en && $urandom_range(0, 3) == 0)) begin
                        pmem_resp = 1'b1;
                        if (cur_wr) mem[cur_addr + 32'(8 * bi)] = pmem_wdata;
                        else pmem_rdata = rd(cur_addr + 32'(8 * bi));
                        bi++;
                        if (bi == BL) begin
                            active = 1'b0; rel_chk = 1'b1; last_cmd_cycles = cmd_cycles;
                        end
                    end
                end else if (stray_en && $urandom_range(0, 7) == 0) begin
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    // Raise the given requests together and serve responses in round-robin order.
    task automatic do_req(input logic ir, input logic [31:0] ia, input logic dr,
                          input logic dw, input logic [31:0] da, input logic [LW-1:0] dwd);
        logic i_pend, d_pend, exp_d, c_wr;
        logic [31:0] c_addr;
        int cyc;
        @(negedge clk);
        i_read = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = dwd;
        i_pend = ir; d_pend = dr | dw;
        exp_d  = d_pend && (!i_pend || lo_m == 1'b0);
        cyc = 0;
        while ((i_pend || d_pend) && cyc < 300) begin
            @(negedge clk); cyc++;
            if (i_resp || d_resp) begin
                chk("resp_excl", i_resp & d_resp, 1'b0);
                chk("resp_port", d_resp, exp_d);
                c_addr = (cmd_addr_q.size() > 0) ? cmd_addr_q.pop_front() : 32'hDEAD_BEEF;
                c_wr   = (cmd_wr_q.size() > 0) ? cmd_wr_q.pop_front() : 1'bx;
                if (d_resp) begin
                    chk("d_cmd_addr", c_addr, align(da));
                    chk("d_cmd_op", c_wr, dw);
                    if (dw) begin
                        for (int b = 0; b < BL; b++)
                            chk("d_wbeat", rd(align(da) + 32'(8 * b)), dwd[64*b +: 64]);
                    end else begin
                        chk("d_rdata", d_rdata, line_of(align(da)));
                    end
                    d_pend = 1'b0; d_read = 1'b0; d_write = 1'b0; lo_m = 1'b1;
                end else begin
                    chk("i_cmd_addr", c_addr, align(ia));
                    chk("i_cmd_op", c_wr, 1'b0);
                    chk("i_rdata", i_rdata, line_of(align(ia)));
                    i_pend = 1'b0; i_read = 1'b0; lo_m = 1'b0;
                end
                exp_d = d_pend;
                @(negedge clk); cyc++;
                chk("resp_pulse", {i_resp, d_resp}, 2'b00);
            end
        end
        chk("req_timeout", {i_pend, d_pend}, 2'b00);
    endtask

    initial begin
        logic [LW-1:0] wd;
        logic [31:0] ra, rda;
        logic rir;
        int dm, cyc;
        rst = 1'b1; lo_m = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd", {pmem_read, pmem_write}, 2'b00);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_addr", pmem_addr, 32'h0);
        chk("rst_line", i_rdata, '0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        // I-cache read with memory delay 10.
        fix_delay = 10;
        do_req(1'b1, 32'h0000_0064, 1'b0, 1'b0, 32'h0, '0);
        chk("i_cmd_cycles", last_cmd_cycles, 14);

        // D-cache writeback with 1111/2222/3333/4444 beats.
        fix_delay = 1;
        for (int b = 0; b < BL; b++) wd[64*b +: 64] = {16{4'(b + 1)}};
        do_req(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0208, wd);
        chk("d_cmd_cycles", last_cmd_cycles, 5);

        // Simultaneous reads, twice: expect I, D, I, D.
        do_req(1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0208, '0);
        do_req(1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_00A0, '0);

        // Conflicting D-cache command behaves as a write.
        wd = {8{32'h5A5A_A5A5}};
        do_req(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300, wd);

        // Error pulse is sticky across transactions.
        fix_delay = 2; err_req = 1'b1;
        do_req(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, '0);
        chk("err_set", err, 1'b1);
        do_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, '0);
        chk("err_sticky", err, 1'b1);

        // Reset after the second beat of a read.
        fix_delay = 0;
        @(negedge clk); i_read = 1'b1; i_addr = 32'h0000_0180;
        cyc = 0;
        do begin @(posedge clk); cyc++; end while (bi != 2 && cyc < 50);
        chk("rst_wait", (cyc < 50), 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_cmd", {pmem_read, pmem_write}, 2'b00);
        chk("midrst_resp", {i_resp, d_resp}, 2'b00);
        chk("midrst_err", err, 1'b0);
        chk("midrst_line", i_rdata, '0);
        @(negedge clk); i_read = 1'b0;
        cmd_addr_q.delete(); cmd_wr_q.delete(); lo_m = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_resp_after_rst", {i_resp, d_resp}, 2'b00);
        end
        do_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_01C4, '0);

        // Randomized traffic with random delays, gaps and stray strobes.
        fix_delay = -1; gap_en = 1'b1; stray_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            rir = 1'($urandom_range(0, 1));
            dm  = $urandom_range(0, 3);
            if (!rir && dm == 0) rir = 1'b1;
            ra  = $urandom & 32'h0000_01FF;
            rda = $urandom & 32'h0000_01FF;
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
            do_req(rir, ra, (dm == 1 || dm == 3), (dm >= 2), rda, wd);
        end
        chk("err_final", err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
